// File: rtl/simple_bfxp_pkg.sv
// Shared constants and length-clamp helper for the bit-field extract-and-place unit.
package simple_bfxp_pkg;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    // Shortens len so the field fits inside both the source and the destination word.
    // Sums are one bit wider than the index fields so start+len never wraps.
    function automatic logic [SHW-1:0] clamp_len(
        input logic [SHW-1:0] start,
        input logic [SHW-1:0] len,
        input logic [SHW-1:0] dest
    );
        logic [SHW:0] l;
        l = {1'b0, len};
        if (({1'b0, start} + l) > (SHW+1)'(XLEN)) begin
            l = (SHW+1)'(XLEN) - {1'b0, start};
        end
        if (({1'b0, dest} + l) > (SHW+1)'(XLEN)) begin
            l = (SHW+1)'(XLEN) - {1'b0, dest};
        end
        return l[SHW-1:0];
    endfunction

endpackage

// File: rtl/simple_bfxp_mask_gen.sv
// Clamped field length and the unshifted low-order field mask.
// Purely combinational; no flow control.
// Backpressure: none, output follows inputs.
module simple_bfxp_mask_gen
    import simple_bfxp_pkg::*;
(
    input  logic [SHW-1:0]  start,
    input  logic [SHW-1:0]  len,
    input  logic [SHW-1:0]  dest,
    output logic [SHW-1:0]  len_clamped,
    output logic [XLEN-1:0] mask
);

    assign len_clamped = clamp_len(start, len, dest);
    // A zero length naturally yields an all-zero mask.
    assign mask        = (XLEN'(1) << len_clamped) - XLEN'(1);

endmodule

// File: rtl/simple_bfxp.sv
// Bit-field extract-and-place: copies rs1[start +: L] into rs2 at dest, L clamped to fit.
// Latency 1 cycle, fully pipelined, one operation per clock.
// Backpressure: none; every rising edge samples all inputs.
module simple_bfxp
    import simple_bfxp_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [SHW-1:0]  start,
    input  logic [SHW-1:0]  len,
    input  logic [SHW-1:0]  dest,
    output logic [XLEN-1:0] rd
);

    logic [SHW-1:0]  len_clamped;
    logic [XLEN-1:0] mask;
    logic [SHW:0]    trim;
    logic [XLEN-1:0] src_shifted;
    logic [XLEN-1:0] field;
    logic [XLEN-1:0] rd_next;

    simple_bfxp_mask_gen u_mask_gen (
        .start       (start),
        .len         (len),
        .dest        (dest),
        .len_clamped (len_clamped),
        .mask        (mask)
    );

    // Field is isolated by shifting the unwanted high bits out and back; a trim of
    // XLEN (L = 0) clears the word entirely.
    assign trim        = (SHW+1)'(XLEN) - {1'b0, len_clamped};
    assign src_shifted = (rs1 >> start) << trim;
    assign field       = src_shifted >> trim;
    assign rd_next     = (rs2 & ~(mask << dest)) | (field << dest);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd <= '0;
        end else begin
            rd <= rd_next;
        end
    end

endmodule

// File: tb/tb_simple_bfxp.sv
// Scoreboard bench: driver pushes expected results, monitor pops one per clock edge.
module tb_simple_bfxp;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rs1   = '0;
    logic [31:0] rs2   = '0;
    logic [4:0]  start = '0;
    logic [4:0]  len   = '0;
    logic [4:0]  dest  = '0;
    logic [31:0] rd;

    typedef struct {
        logic [31:0] exp;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    simple_bfxp dut (
        .clock (clock),
        .reset (reset),
        .rs1   (rs1),
        .rs2   (rs2),
        .start (start),
        .len   (len),
        .dest  (dest),
        .rd    (rd)
    );

    always #5 clock = ~clock;

    // Reference: bit-by-bit copy of the clamped field, lengths as plain integers.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input int s, input int l, input int d);
        int          n;
        logic [31:0] r;
        n = l;
        if (32 - s < n) n = 32 - s;
        if (32 - d < n) n = 32 - d;
        r = b;
        for (int i = 0; i < n; i++) r[d + i] = a[s + i];
        return r;
    endfunction

    task automatic drive_now(input logic [31:0] a, input logic [31:0] b, input logic [4:0] s,
                             input logic [4:0] l, input logic [4:0] d,
                             input logic [31:0] e, input int id);
        exp_t t;
        rs1 = a; rs2 = b; start = s; len = l; dest = d;
        t.exp = e;
        t.id  = id;
        exp_q.push_back(t);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] s,
                         input logic [4:0] l, input logic [4:0] d,
                         input logic [31:0] e, input int id);
        @(negedge clock);
        drive_now(a, b, s, l, d, e, id);
    endtask

    task automatic issue_rand(input int id);
        logic [31:0] a, b;
        logic [4:0]  s, l, d;
        a = $urandom; b = $urandom;
        s = 5'($urandom_range(0, 31));
        l = 5'($urandom_range(0, 31));
        d = 5'($urandom_range(0, 31));
        issue(a, b, s, l, d, model(a, b, int'(s), int'(l), int'(d)), id);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: rd=%h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each edge outside reset retires the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rd !== e.exp) begin
                    errors++;
                    $display("FAIL vec%0d: rd=%h expected %h", e.id, rd, e.exp);
                end
            end
        end
    end

    initial begin
        #12;
        check("reset_init", rd, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        issue(32'h12345678, 32'hFFFFFFFF, 5'd4,  5'd8,  5'd16, 32'hFF67FFFF, 1);
        issue(32'hDEADBEEF, 32'hA5A5A5A5, 5'd3,  5'd0,  5'd7,  32'hA5A5A5A5, 2);
        issue(32'hF0000000, 32'h00000000, 5'd28, 5'd10, 5'd0,  32'h0000000F, 3);
        issue(32'h000000FF, 32'h00000000, 5'd0,  5'd8,  5'd28, 32'hF0000000, 4);
        issue(32'h000000FF, 32'h12345678, 5'd0,  5'd8,  5'd28, 32'hF2345678, 5);
        issue(32'h80000000, 32'hFFFFFFFE, 5'd31, 5'd31, 5'd0,  32'hFFFFFFFF, 6);
        issue(32'h0000FFFF, 32'h00000000, 5'd0,  5'd31, 5'd1,  32'h0001FFFE, 7);

        for (int i = 0; i < 1000; i++) issue_rand(100 + i);

        // Reset mid-stream, away from any clock edge.
        @(posedge clock);
        #3;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("reset_async", rd, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold", rd, 32'h0);

        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_release", rd, 32'h0);
        drive_now(32'h12345678, 32'h00000000, 5'd8, 5'd8, 5'd0, 32'h00000056, 8);
        for (int i = 0; i < 20; i++) issue_rand(2000 + i);

        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
